gpio_port: RTL
==============

GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the data bus and of every GPIO vector.
REQ-002 Parameter ADDR_WIDTH, default 3, SHALL set the width of the word address.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; it SHALL clear all state immediately while low.
REQ-005 Port req, input, 1: the CPU data-bus access strobe, sampled on each rising edge of clk.
REQ-006 Port we, input, 1: 1 = write and 0 = read, qualified by req.
REQ-007 Port addr, input, ADDR_WIDTH: the register word address, qualified by req.
REQ-008 Port wdata, input, DATA_WIDTH: the write data, qualified by req & we.
REQ-009 Port rdata, output, DATA_WIDTH: the read data, valid only while ack = 1.
REQ-010 Port ack, output, 1: the one-cycle response to an accepted req.
REQ-011 Port gpio_in, input, DATA_WIDTH: asynchronous external pin inputs.
REQ-012 Port gpio_out, output, DATA_WIDTH: the output data register, driven directly from a flop.
REQ-013 Port gpio_oe, output, DATA_WIDTH: the per-bit output enable (the DIR register).
REQ-014 Port irq, output, 1: the level interrupt to the CPU.

Function
REQ-015 The register map (word address) SHALL be:
- 0 OUT, read/write
- 1 IN, read-only (synchronized pins)
- 2 DIR, read/write
- 3 RISE, sticky rising-edge status, write-1-to-clear
- 4 IEN, read/write interrupt enable
- 5-7 read as 0; writes ignored
REQ-016 Every cycle in which req = 1 SHALL be accepted; there is no backpressure.
REQ-017 ack SHALL be 1 in the cycle after each accepted req and 0 otherwise.
REQ-018 req asserted on consecutive cycles SHALL produce ack on consecutive cycles.
REQ-019 On a read, rdata SHALL present the addressed register value as sampled at the accepting edge.
REQ-020 rdata SHALL be 0 whenever ack = 0.
REQ-021 A write SHALL update the target register at the accepting edge, so gpio_out and gpio_oe change one cycle after req.
REQ-022 A read that directly follows a write to the same register SHALL return the new value.
REQ-023 A write to IN SHALL have no effect, and its ack SHALL still be generated.
REQ-024 gpio_in SHALL pass through a 2-flop synchronizer; IN SHALL return the second-stage value.
REQ-025 A third flop SHALL hold the previous synchronized value; rise = sync & ~prev.
REQ-026 A RISE bit SHALL set on the 3rd rising clk edge after gpio_in goes high and stays stable.
REQ-027 A pulse shorter than one clock period is not guaranteed to be captured.
REQ-028 RISE bits SHALL stay set until written 1; writing 0 to a bit SHALL leave it unchanged.
REQ-029 If a rise event and a write-1 clear hit the same bit in the same cycle, set SHALL win.
REQ-030 irq SHALL be |(RISE & IEN), derived only from flop outputs with no combinational path from bus or pin inputs.
REQ-031 irq SHALL follow RISE/IEN changes in the same cycle those registers update.
REQ-032 Because the synchronizer and prev flops reset to 0, a pin already high at reset release SHALL set its RISE bit 3 edges after release.

Reset
REQ-033 While reset = 0, the following SHALL all read 0: OUT, DIR, RISE, IEN, the synchronizer flops, the prev flops, ack, rdata, gpio_out, gpio_oe and irq.
REQ-034 A request accepted in the cycle that reset asserts SHALL be discarded: no ack and no register update after reset release.
REQ-035 The first edge after reset deasserts SHALL accept req normally.

Verification
REQ-036 Reset check: hold reset = 0 for 2 cycles, then release with gpio_in = 0 -> all outputs 0, and reads of addresses 0-7 return 0 with ack one cycle after each req.
REQ-037 Write-then-read: write OUT = 0xFFFFFF00 and DIR = 0x0000FFFF -> gpio_out = 0xFFFFFF00 and gpio_oe = 0x0000FFFF one cycle later; a back-to-back read of OUT returns 0xFFFFFF00.
REQ-038 Edge capture: with IEN = 0x1, drive gpio_in = 0x1 -> RISE = 0x1 and irq = 1 on the 3rd edge; IN reads 0x1.
REQ-039 Clearing the edge: write RISE = 0x1 -> RISE = 0 and irq = 0 next cycle; a second write of 0x1 with gpio_in held high keeps RISE = 0.
REQ-040 Set-versus-clear collision: time a write-1 to RISE bit 4 for the exact cycle gpio_in[4] rises through the synchronizer -> RISE[4] = 1 afterwards.
REQ-041 Reset during access: assert reset in the same cycle as a write of OUT = 0x700A -> no ack, and OUT = 0 after release.

Source files
------------

// File: rtl/gpio_port_if.sv
// CPU data-bus bundle for the GPIO port.
// The CPU side drives a request strobe, direction, word address and write data.
// The peripheral answers one cycle later with ack and, for reads, rdata.
interface gpio_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;

  // CPU side: issues requests and receives responses
  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  // Peripheral side: accepts requests and returns responses
  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );

endinterface

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port.
//   word 0 OUT  : output data register, drives gpio_out directly
//   word 1 IN   : synchronized pin values, read-only
//   word 2 DIR  : per-bit output enable, drives gpio_oe directly
//   word 3 RISE : sticky rising-edge status, write-1-to-clear
//   word 4 IEN  : interrupt enable mask for RISE
//   words 5-7   : read as zero, writes ignored
// Every request is accepted and answered with a single-cycle ack on the next cycle.
// irq is the OR of RISE & IEN and is built only from flop outputs.
module gpio_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  gpio_port_if.slave            bus,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [DATA_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  // Register word addresses
  localparam logic [ADDR_WIDTH-1:0] ADDR_OUT  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IN   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_DIR  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RISE = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IEN  = ADDR_WIDTH'(4);

  // Pin synchronizer (two stages) and previous-value flop for edge detection
  logic [DATA_WIDTH-1:0] r_sync1;
  logic [DATA_WIDTH-1:0] r_sync2;
  logic [DATA_WIDTH-1:0] r_prev;

  // Software-visible registers
  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] r_dir;
  logic [DATA_WIDTH-1:0] r_rise;
  logic [DATA_WIDTH-1:0] r_ien;

  // Bus response registers
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Decoded access strobes
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_wr_out;
  logic                  w_wr_dir;
  logic                  w_wr_rise;
  logic                  w_wr_ien;

  // Edge detection and RISE next-state
  logic [DATA_WIDTH-1:0] w_rise_evt;
  logic [DATA_WIDTH-1:0] w_rise_clr;
  logic [DATA_WIDTH-1:0] w_rise_next;

  // Read multiplexer output
  logic [DATA_WIDTH-1:0] w_rd_val;

  assign w_wr_en   = bus.req & bus.we;
  assign w_rd_en   = bus.req & ~bus.we;
  assign w_wr_out  = w_wr_en & (bus.addr == ADDR_OUT);
  assign w_wr_dir  = w_wr_en & (bus.addr == ADDR_DIR);
  assign w_wr_rise = w_wr_en & (bus.addr == ADDR_RISE);
  assign w_wr_ien  = w_wr_en & (bus.addr == ADDR_IEN);
  // Writes to IN and to unmapped words decode to nothing; they are still acked.

  // A rise event is the synchronized value being 1 where the previous sample was 0.
  assign w_rise_evt = r_sync2 & ~r_prev;

  // Per-bit RISE update: a new event sets the bit even if software clears it in
  // the same cycle, so an edge arriving during a clear is never lost.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_rise_bit
      assign w_rise_clr[gi]  = w_wr_rise & bus.wdata[gi];
      assign w_rise_next[gi] = w_rise_evt[gi] | (r_rise[gi] & ~w_rise_clr[gi]);
    end
  endgenerate

  // Two-flop synchronizer for the asynchronous pins, plus the previous-value stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Read/write control registers, updated at the edge that accepts the write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out <= '0;
      r_dir <= '0;
      r_ien <= '0;
    end else begin
      if (w_wr_out) begin
        r_out <= bus.wdata;
      end
      if (w_wr_dir) begin
        r_dir <= bus.wdata;
      end
      if (w_wr_ien) begin
        r_ien <= bus.wdata;
      end
    end
  end

  // Sticky rising-edge status register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rise <= '0;
    end else begin
      r_rise <= w_rise_next;
    end
  end

  // Read multiplexer: register values as they stand before the accepting edge
  always_comb begin
    w_rd_val = '0;
    unique case (bus.addr)
      ADDR_OUT:  w_rd_val = r_out;
      ADDR_IN:   w_rd_val = r_sync2;
      ADDR_DIR:  w_rd_val = r_dir;
      ADDR_RISE: w_rd_val = r_rise;
      ADDR_IEN:  w_rd_val = r_ien;
      default:   w_rd_val = '0;
    endcase
  end

  // Bus response: ack one cycle after every request; rdata only carries read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= bus.req;
      r_rdata <= w_rd_en ? w_rd_val : '0;
    end
  end

  assign bus.ack   = r_ack;
  assign bus.rdata = r_rdata;
  assign gpio_out  = r_out;
  assign gpio_oe   = r_dir;
  assign irq       = |(r_rise & r_ien);

endmodule
